// File: rtl/address_sequencer_pkg.sv
// Shared definitions for the address sequencer: sequencer state encoding
// and the default address width / step size.
package address_sequencer_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_STEP   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } seq_state_e;

endpackage

// File: rtl/address_incrementer.sv
// Adds or subtracts a fixed step from an address.
// The result wraps modulo 2^ADDR_W.
module address_incrementer
  import address_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned STEP   = DEFAULT_STEP
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              down,
  output logic [ADDR_W-1:0] result
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  assign result = down ? (addr - STEP_V) : (addr + STEP_V);

endmodule

// File: rtl/address_sequencer.sv
// Address register with load/single-step control and a fixed-stride burst
// engine that walks up or down one beat per accepted memory transfer.
module address_sequencer
  import address_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned STEP    = DEFAULT_STEP,
  parameter int unsigned LEN_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_data,
  input  logic [$clog2(NUM_SRC)-1:0]  src_sel,
  input  logic                        load,
  input  logic                        inc,
  input  logic                        burst_start,
  input  logic [LEN_W-1:0]            burst_len,
  input  logic                        burst_down,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           out_mem_address,
  output logic [ADDR_W-1:0]           out_inc_address,
  output logic                        busy,
  output logic [LEN_W-1:0]            beat_idx,
  output logic                        burst_done
);

  seq_state_e        state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [LEN_W-1:0]  beat_q, beat_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic              down_q, down_n;
  logic              done_q, done_n;

  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] step_addr;
  logic              step_down;

  // Out-of-range selects fall back to the highest source.
  always_comb begin
    sel_addr = src_data[(NUM_SRC-1)*ADDR_W +: ADDR_W];
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (32'(src_sel) == k) sel_addr = src_data[k*ADDR_W +: ADDR_W];
    end
  end

  // Single-step in IDLE is always upward; bursts use the latched direction.
  assign step_down = (state_q == ST_BURST) ? down_q : 1'b0;

  address_incrementer #(.ADDR_W(ADDR_W), .STEP(STEP)) u_out_inc (
    .addr   (addr_q),
    .down   (1'b0),
    .result (out_inc_address)
  );

  address_incrementer #(.ADDR_W(ADDR_W), .STEP(STEP)) u_next_inc (
    .addr   (addr_q),
    .down   (step_down),
    .result (step_addr)
  );

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    beat_n  = beat_q;
    len_n   = len_q;
    down_n  = down_q;
    done_n  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A burst starting this cycle suppresses inc but still honours load.
        if (load) begin
          addr_n = sel_addr;
        end else if (inc && !burst_start) begin
          addr_n = step_addr;
        end
        if (burst_start) begin
          len_n   = burst_len;
          down_n  = burst_down;
          beat_n  = '0;
          state_n = ST_BURST;
        end
      end
      ST_BURST: begin
        if (mem_ready) begin
          addr_n = step_addr;
          if (beat_q == len_q) begin
            beat_n  = '0;
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            beat_n = beat_q + LEN_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      down_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      beat_q  <= beat_n;
      len_q   <= len_n;
      down_q  <= down_n;
      done_q  <= done_n;
    end
  end

  assign out_mem_address = addr_q;
  assign busy            = (state_q == ST_BURST);
  assign beat_idx        = beat_q;
  assign burst_done      = done_q;

endmodule

// File: tb/tb_address_sequencer.sv
// Scoreboard bench for address_sequencer: directed scenarios plus random
// traffic, checked every cycle against a beat-count reference model.
module tb_address_sequencer;

  localparam int ADDR_W  = 32;
  localparam int NUM_SRC = 3;
  localparam int STEP    = 4;
  localparam int LEN_W   = 4;

  logic                      clk = 1'b0;
  logic                      rst, load, inc, burst_start, burst_down, mem_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_data;
  logic [1:0]                src_sel;
  logic [LEN_W-1:0]          burst_len;
  logic [ADDR_W-1:0]         out_mem_address, out_inc_address;
  logic                      busy;
  logic [LEN_W-1:0]          beat_idx;
  logic                      burst_done;

  address_sequencer #(
    .ADDR_W  (ADDR_W),
    .NUM_SRC (NUM_SRC),
    .STEP    (STEP),
    .LEN_W   (LEN_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src_data        (src_data),
    .src_sel         (src_sel),
    .load            (load),
    .inc             (inc),
    .burst_start     (burst_start),
    .burst_len       (burst_len),
    .burst_down      (burst_down),
    .mem_ready       (mem_ready),
    .out_mem_address (out_mem_address),
    .out_inc_address (out_inc_address),
    .busy            (busy),
    .beat_idx        (beat_idx),
    .burst_done      (burst_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        busy;
    logic [3:0]  beat;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a burst is its start address plus a count of accepted beats.
  logic [31:0] m_addr, m_start;
  bit          m_busy, m_down, m_done;
  int          m_len, m_cnt;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step();
    logic [31:0] a;
    int          idx;
    if (rst) begin
      m_addr = '0; m_busy = 0; m_done = 0; m_cnt = 0; m_len = 0; m_down = 0;
    end else if (!m_busy) begin
      m_done = 0;
      a = m_addr;
      idx = (int'(src_sel) >= NUM_SRC) ? NUM_SRC - 1 : int'(src_sel);
      if (load) a = src_data[idx*ADDR_W +: ADDR_W];
      else if (inc && !burst_start) a = m_addr + 32'(STEP);
      m_addr = a;
      if (burst_start) begin
        m_busy = 1; m_start = a; m_len = int'(burst_len); m_down = burst_down; m_cnt = 0;
      end
    end else begin
      m_done = 0;
      if (mem_ready) begin
        m_cnt++;
        m_addr = m_down ? m_start - 32'(m_cnt * STEP) : m_start + 32'(m_cnt * STEP);
        if (m_cnt == m_len + 1) begin
          m_busy = 0; m_done = 1; m_cnt = 0;
        end
      end
    end
    exp_q.push_back('{addr: m_addr, busy: m_busy,
                      beat: (m_busy ? 4'(m_cnt) : 4'd0), done: m_done});
  endfunction

  task automatic drive(bit r, bit ld, logic [1:0] sel, bit in, bit bs,
                       logic [3:0] len, bit dn, bit rdy);
    rst = r; load = ld; src_sel = sel; inc = in; burst_start = bs;
    burst_len = len; burst_down = dn; mem_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit rdy);
    drive(0, 0, 2'd0, 0, 0, 4'd0, 0, rdy);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("mem_address", out_mem_address, e.addr);
      chk("inc_address", out_inc_address, e.addr + 32'(STEP));
      chk("busy",        32'(busy),       32'(e.busy));
      chk("beat_idx",    32'(beat_idx),   32'(e.beat));
      chk("burst_done",  32'(burst_done), 32'(e.done));
    end
  end

  initial begin
    src_data = '0;
    drive(1, 0, 2'd0, 0, 0, 4'd0, 0, 0);
    drive(1, 0, 2'd0, 0, 0, 4'd0, 0, 0);
    chk("reset_addr", out_mem_address, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Load then single-step.
    src_data[2*ADDR_W +: ADDR_W] = 32'h1000;
    drive(0, 1, 2'd2, 0, 0, 4'd0, 0, 0);
    chk("load_src2", out_mem_address, 32'h1000);
    drive(0, 0, 2'd0, 1, 0, 4'd0, 0, 0);
    chk("inc_addr", out_mem_address, 32'h1004);
    chk("inc_next", out_inc_address, 32'h1008);

    // Upward burst of four beats, memory always ready.
    src_data[1*ADDR_W +: ADDR_W] = 32'h2000;
    drive(0, 1, 2'd1, 0, 0, 4'd0, 0, 0);
    drive(0, 0, 2'd0, 0, 1, 4'd3, 0, 1);
    chk("burst_beat0", out_mem_address, 32'h2000);
    repeat (3) idle(1);
    chk("burst_beat3", out_mem_address, 32'h200C);
    idle(1);
    chk("burst_end_addr", out_mem_address, 32'h2010);
    chk("burst_end_done", 32'(burst_done), 32'd1);
    idle(0);
    chk("done_one_cycle", 32'(burst_done), 32'd0);

    // Downward burst wrapping through zero with a stall.
    src_data[0 +: ADDR_W] = 32'h4;
    drive(0, 1, 2'd0, 0, 0, 4'd0, 0, 0);
    drive(0, 0, 2'd0, 0, 1, 4'd1, 1, 1);
    idle(1);
    chk("down_beat1", out_mem_address, 32'h0);
    idle(0);
    chk("down_stall", out_mem_address, 32'h0);
    idle(1);
    chk("down_wrap", out_mem_address, 32'hFFFF_FFFC);

    // load + inc + burst_start together: loaded address is beat 0, inc dropped.
    src_data[0 +: ADDR_W] = 32'h300;
    drive(0, 1, 2'd0, 1, 1, 4'd0, 0, 0);
    chk("combo_beat0", out_mem_address, 32'h300);
    idle(1);
    chk("combo_final", out_mem_address, 32'h304);

    // Reset mid-burst aborts without a completion pulse.
    src_data[0 +: ADDR_W] = 32'h5000;
    drive(0, 1, 2'd0, 0, 1, 4'd7, 0, 1);
    idle(1);
    idle(1);
    chk("abort_at_beat2", 32'(beat_idx), 32'd2);
    drive(1, 0, 2'd0, 0, 0, 4'd0, 0, 1);
    chk("abort_addr", out_mem_address, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    idle(1);
    chk("abort_no_done", 32'(burst_done), 32'd0);

    // Out-of-range select clamps; control inputs ignored during a burst.
    src_data[2*ADDR_W +: ADDR_W] = 32'hABC0;
    drive(0, 1, 2'd3, 0, 0, 4'd0, 0, 0);
    chk("sel_clamp", out_mem_address, 32'hABC0);
    drive(0, 0, 2'd0, 0, 1, 4'd1, 0, 0);
    drive(0, 1, 2'd0, 1, 1, 4'd5, 1, 1);
    chk("ignore_in_burst", out_mem_address, 32'hABC4);
    idle(1);
    chk("ignore_final", out_mem_address, 32'hABC8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 25 == 0) src_data = {$urandom, $urandom, $urandom};
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, 2'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0, 4'($urandom),
            1'($urandom), $urandom_range(0, 9) < 7);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/address_sequencer.md
ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of selectable address sources (>=2).
REQ-003 SHALL have parameter STEP, default 4, byte increment per beat.
REQ-004 SHALL have parameter LEN_W, default 4, burst-length field width; a burst carries 1..2^LEN_W beats.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port src_data, input, NUM_SRC*ADDR_W, flattened sources; source k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port src_sel, input, $clog2(NUM_SRC), source select.
REQ-009 SHALL have port load, input, 1, load the selected source into the address register.
REQ-010 SHALL have port inc, input, 1, single-step advance by +STEP.
REQ-011 SHALL have port burst_start, input, 1, begin a burst.
REQ-012 SHALL have port burst_len, input, LEN_W, beats minus one.
REQ-013 SHALL have port burst_down, input, 1, 1 = decrement by STEP per beat, 0 = increment.
REQ-014 SHALL have port mem_ready, input, 1, memory accepted the current beat.
REQ-015 SHALL have port out_mem_address, output, ADDR_W, current address register.
REQ-016 SHALL have port out_inc_address, output, ADDR_W, combinational out_mem_address + STEP.
REQ-017 SHALL have port busy, output, 1, high while in BURST.
REQ-018 SHALL have port beat_idx, output, LEN_W, index of the current beat.
REQ-019 SHALL have port burst_done, output, 1, single-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE and BURST.
REQ-021 In IDLE, priority SHALL be load > inc; burst_start is evaluated independently of both.
REQ-022 load in IDLE SHALL write the selected source to the register next cycle; src_sel >= NUM_SRC SHALL select source NUM_SRC-1.
REQ-023 inc in IDLE without load SHALL advance the register by +STEP.
REQ-024 burst_start in IDLE SHALL latch burst_len and burst_down, clear beat_idx and enter BURST; if load is also high, beat 0 SHALL use the loaded address; inc SHALL be ignored that cycle.
REQ-025 In BURST with mem_ready=0, address, beat_idx and state SHALL hold.
REQ-026 In BURST with mem_ready=1 and beat_idx < latched length, the address SHALL advance by ±STEP and beat_idx SHALL increment.
REQ-027 In BURST with mem_ready=1 and beat_idx == latched length, the address SHALL advance by ±STEP (write-back value start ± (len+1)*STEP), beat_idx SHALL clear, and the state SHALL return to IDLE.
REQ-028 burst_done SHALL be registered, high exactly during the first IDLE cycle after a completed burst.
REQ-029 load, inc and burst_start SHALL be ignored while in BURST.
REQ-030 All address arithmetic SHALL wrap modulo 2^ADDR_W in both directions.
REQ-031 busy SHALL equal (state == BURST), registered.

Reset
REQ-032 rst SHALL set the address to 0, state to IDLE, beat_idx to 0, burst_done to 0, and the latched length and direction to 0.
REQ-033 rst SHALL take priority over all inputs; rst during BURST SHALL abort the burst with no burst_done pulse.

Structure
REQ-034 The state encoding, the default ADDR_W and the default STEP SHALL reside in the shared cpu package.
REQ-035 The ±STEP adder SHALL be a sub-module named address_incrementer, instantiated for both out_inc_address and the next-address path.

Verification
REQ-036 Reset, then load src 2 = 0x1000, then inc -> out_mem_address 0x1000, then 0x1004; out_inc_address 0x1008.
REQ-037 Load 0x2000, then burst_start len=3 up with mem_ready always 1 -> addresses 0x2000, 0x2004, 0x2008, 0x200C, then 0x2010 with burst_done for one cycle; busy high exactly 4 cycles.
REQ-038 Burst len=1 down from 0x4, mem_ready toggling 1,0,1 -> addresses 0x4, 0x0 (held during the stall), then wrap to 0xFFFFFFFC.
REQ-039 load, inc and burst_start asserted together with src 0 = 0x300, len=0 -> beat 0 at 0x300, final address 0x304, inc ignored.
REQ-040 rst asserted at beat 2 of a len=7 burst -> next cycle address 0, busy 0, burst_done never asserted.
REQ-041 src_sel = 3 with NUM_SRC=3 -> source 2 loaded; inc asserted during BURST -> no extra advance.
